// File: rtl/gcm_pkg.sv
// Shared types and helpers for the GCM GHASH/tag engine.
// Blocks use GCM bit order: index 0 is the leftmost (most significant) bit.
package gcm_pkg;

   typedef logic [0:127] gcm_block_t;

   localparam gcm_block_t GCM_R = {8'hE1, 120'd0};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ACCEPT   = 3'd1,
      S_MULT     = 3'd2,
      S_LEN_MULT = 3'd3,
      S_DONE     = 3'd4
   } gcm_state_e;

   // Keeps the first 'bytes' bytes of the block and zeroes the rest.
   function automatic gcm_block_t pad_block(input gcm_block_t blk, input logic [4:0] bytes);
      gcm_block_t mask;
      for (int k = 0; k < 16; k++) begin
         mask[8*k +: 8] = (5'(k) < bytes) ? 8'hFF : 8'h00;
      end
      return blk & mask;
   endfunction

endpackage

// File: rtl/gcm_gf_mult_serial.sv
// Digit-serial GF(2^128) multiplier: Z = X * H, DIGIT_W bits of X per cycle.
// The first digit is folded into the load cycle; Z holds its value after o_done.
module gcm_gf_mult_serial
   import gcm_pkg::*;
#(
   parameter int DIGIT_W = 8
) (
   input  logic       clk,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  gcm_block_t i_x,
   input  gcm_block_t i_h,
   output logic       o_done,
   output gcm_block_t o_z
);

   localparam int MULT_CYC = 128 / DIGIT_W;
   localparam int CNT_W    = $clog2(MULT_CYC + 1);

   gcm_block_t       x_q, x_d, v_q, v_d, z_q, z_d;
   gcm_block_t       x_t, v_t, z_t;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;

   // One digit of shift-and-add; a start restarts from the new operands.
   always_comb begin
      x_t = i_start ? i_x : x_q;
      v_t = i_start ? i_h : v_q;
      z_t = i_start ? 128'd0 : z_q;
      for (int j = 0; j < DIGIT_W; j++) begin
         z_t = x_t[j] ? (z_t ^ v_t) : z_t;
         v_t = v_t[127] ? ((v_t >> 1'b1) ^ GCM_R) : (v_t >> 1'b1);
      end
      x_d    = x_q;
      v_d    = v_q;
      z_d    = z_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (i_start || busy_q) begin
         x_d    = x_t << DIGIT_W;
         v_d    = v_t;
         z_d    = z_t;
         cnt_d  = i_start ? CNT_W'(1) : (cnt_q + CNT_W'(1));
         busy_d = (cnt_d != CNT_W'(MULT_CYC));
         done_d = (cnt_d == CNT_W'(MULT_CYC));
      end else begin
         busy_d = 1'b0;
      end
   end

   // Operand, accumulator and digit counter registers.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         x_q    <= 128'd0;
         v_q    <= 128'd0;
         z_q    <= 128'd0;
         cnt_q  <= CNT_W'(0);
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         x_q    <= x_d;
         v_q    <= v_d;
         z_q    <= z_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign o_done = done_q;
   assign o_z    = z_q;

endmodule

// File: rtl/gcm_ghash_serial.sv
// GHASH/tag engine: absorbs AAD/CT blocks, appends the length block, emits tag.
// The running hash Y lives in the multiplier's Z register between blocks.
module gcm_ghash_serial
   import gcm_pkg::*;
#(
   parameter int DIGIT_W = 8
) (
   input  logic       clk,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  gcm_block_t i_h,
   input  gcm_block_t i_ek0,
   input  logic       i_valid,
   output logic       o_ready,
   input  gcm_block_t i_data,
   input  logic       i_type,
   input  logic [4:0] i_bytes,
   input  logic       i_last,
   input  logic       i_final,
   output logic       o_tag_valid,
   output gcm_block_t o_tag,
   output logic       o_error
);

   gcm_state_e  state_q, state_d;
   gcm_block_t  h_q, h_d, ek0_q, ek0_d, tag_q, tag_d;
   logic [63:0] aad_q, aad_d, ct_q, ct_d;
   logic        last_q, last_d, seen_ct_q, seen_ct_d;
   logic        aad_part_q, aad_part_d, ct_part_q, ct_part_d;
   logic        len_go_q, len_go_d, ready_q, ready_d;
   logic        tag_valid_q, tag_valid_d, error_q, error_d;

   logic        mult_start, mult_done, hs, blk_err;
   gcm_block_t  mult_x, mult_z;

   gcm_gf_mult_serial #(.DIGIT_W(DIGIT_W)) u_mult (
      .clk       (clk),
      .i_reset_n (i_reset_n),
      .i_start   (mult_start),
      .i_x       (mult_x),
      .i_h       (h_q),
      .o_done    (mult_done),
      .o_z       (mult_z)
   );

   // Next-state, counters, protocol checks and multiplier launch.
   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      ek0_d       = ek0_q;
      tag_d       = tag_q;
      aad_d       = aad_q;
      ct_d        = ct_q;
      last_d      = last_q;
      seen_ct_d   = seen_ct_q;
      aad_part_d  = aad_part_q;
      ct_part_d   = ct_part_q;
      len_go_d    = len_go_q;
      tag_valid_d = tag_valid_q;
      error_d     = error_q;
      mult_start  = 1'b0;
      mult_x      = 128'd0;
      hs          = i_valid & ready_q;
      blk_err     = (i_bytes == 5'd0) | (i_bytes > 5'd16) | (~i_type & seen_ct_q) |
                    (i_type ? ct_part_q : aad_part_q);
      if (i_start) begin
         // Clearing Y is a multiply of zero, which also cancels any multiply in flight.
         state_d     = S_ACCEPT;
         h_d         = i_h;
         ek0_d       = i_ek0;
         aad_d       = 64'd0;
         ct_d        = 64'd0;
         last_d      = 1'b0;
         seen_ct_d   = 1'b0;
         aad_part_d  = 1'b0;
         ct_part_d   = 1'b0;
         len_go_d    = 1'b0;
         tag_valid_d = 1'b0;
         error_d     = 1'b0;
         mult_start  = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ACCEPT: begin
               if (hs && blk_err) begin
                  error_d = 1'b1;
               end else if (hs) begin
                  mult_start = 1'b1;
                  mult_x     = mult_z ^ pad_block(i_data, i_bytes);
                  last_d     = i_last;
                  seen_ct_d  = seen_ct_q | i_type;
                  if (i_type) begin
                     ct_d      = ct_q + {56'd0, i_bytes, 3'b000};
                     ct_part_d = (i_bytes != 5'd16);
                  end else begin
                     aad_d      = aad_q + {56'd0, i_bytes, 3'b000};
                     aad_part_d = (i_bytes != 5'd16);
                  end
                  state_d = S_MULT;
               end else if (i_final) begin
                  len_go_d = 1'b1;
                  state_d  = S_LEN_MULT;
               end else begin
                  state_d = S_ACCEPT;
               end
            end
            S_MULT: begin
               if (mult_done && last_q) begin
                  len_go_d = 1'b1;
                  state_d  = S_LEN_MULT;
               end else if (mult_done) begin
                  state_d = S_ACCEPT;
               end else begin
                  state_d = S_MULT;
               end
            end
            S_LEN_MULT: begin
               if (len_go_q) begin
                  mult_start = 1'b1;
                  mult_x     = mult_z ^ {aad_q, ct_q};
                  len_go_d   = 1'b0;
               end else if (mult_done) begin
                  tag_d       = mult_z ^ ek0_q;
                  tag_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  state_d = S_LEN_MULT;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
      ready_d = (state_d == S_ACCEPT);
   end

   // Control, counter and output registers.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= S_IDLE;
         h_q         <= 128'd0;
         ek0_q       <= 128'd0;
         tag_q       <= 128'd0;
         aad_q       <= 64'd0;
         ct_q        <= 64'd0;
         last_q      <= 1'b0;
         seen_ct_q   <= 1'b0;
         aad_part_q  <= 1'b0;
         ct_part_q   <= 1'b0;
         len_go_q    <= 1'b0;
         ready_q     <= 1'b0;
         tag_valid_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         ek0_q       <= ek0_d;
         tag_q       <= tag_d;
         aad_q       <= aad_d;
         ct_q        <= ct_d;
         last_q      <= last_d;
         seen_ct_q   <= seen_ct_d;
         aad_part_q  <= aad_part_d;
         ct_part_q   <= ct_part_d;
         len_go_q    <= len_go_d;
         ready_q     <= ready_d;
         tag_valid_q <= tag_valid_d;
         error_q     <= error_d;
      end
   end

   assign o_ready     = ready_q;
   assign o_tag_valid = tag_valid_q;
   assign o_tag       = tag_q;
   assign o_error     = error_q;

endmodule

// File: tb/tb_gcm_ghash_serial.sv
// Self-checking bench for gcm_ghash_serial: GCM vectors, protocol corners and
// random messages checked against a carry-less-multiply GHASH model.
module tb_gcm_ghash_serial;

   localparam logic [127:0] TC_EK0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
   localparam logic [127:0] TC_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] TC_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [127:0] TC_TAG = 128'hab6e47d42cec13bdf53a67b21257bddf;
   localparam logic [127:0] ID_H   = {1'b1, 127'd0};
   localparam int           M8     = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, start, valid, typ, last, fin;
   logic [127:0] h_in, ek0_in, data;
   logic [4:0]   bytes;
   logic         rdy8, tv8, err8, rdy1, tv1, err1, rdy128, tv128, err128;
   logic [127:0] tag8, tag1, tag128;

   int n_tests = 0;
   int n_fail  = 0;

   gcm_ghash_serial #(.DIGIT_W(8)) u_dut (
      .clk(clk), .i_reset_n(rst_n), .i_start(start), .i_h(h_in), .i_ek0(ek0_in),
      .i_valid(valid), .o_ready(rdy8), .i_data(data), .i_type(typ), .i_bytes(bytes),
      .i_last(last), .i_final(fin), .o_tag_valid(tv8), .o_tag(tag8), .o_error(err8));

   gcm_ghash_serial #(.DIGIT_W(1)) u_dut_w1 (
      .clk(clk), .i_reset_n(rst_n), .i_start(start), .i_h(h_in), .i_ek0(ek0_in),
      .i_valid(valid), .o_ready(rdy1), .i_data(data), .i_type(typ), .i_bytes(bytes),
      .i_last(last), .i_final(fin), .o_tag_valid(tv1), .o_tag(tag1), .o_error(err1));

   gcm_ghash_serial #(.DIGIT_W(128)) u_dut_w128 (
      .clk(clk), .i_reset_n(rst_n), .i_start(start), .i_h(h_in), .i_ek0(ek0_in),
      .i_valid(valid), .o_ready(rdy128), .i_data(data), .i_type(typ), .i_bytes(bytes),
      .i_last(last), .i_final(fin), .o_tag_valid(tv128), .o_tag(tag128), .o_error(err128));

   // Reference model: polynomial arithmetic on bit-reflected values.
   function automatic logic [127:0] rev128(input logic [127:0] a);
      logic [127:0] r;
      for (int i = 0; i < 128; i++) r[i] = a[127-i];
      return r;
   endfunction

   function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
      logic [255:0] p;
      logic [127:0] pa, pb;
      pa = rev128(a);
      pb = rev128(b);
      p  = 256'd0;
      for (int i = 0; i < 128; i++) if (pa[i]) p = p ^ ({128'd0, pb} << i);
      for (int i = 254; i >= 128; i--) begin
         if (p[i]) begin
            p[i] = 1'b0;
            p[i-128 +: 8] = p[i-128 +: 8] ^ 8'h87;
         end
      end
      return rev128(p[127:0]);
   endfunction

   function automatic logic [127:0] pad_ref(input logic [127:0] d, input logic [4:0] b);
      logic [127:0] ones;
      ones = {128{1'b1}};
      return d & ~(ones >> (8 * int'(b)));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic begin_msg(input logic [127:0] hh, input logic [127:0] ee);
      h_in = hh; ek0_in = ee; valid = 1'b0; fin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [127:0] d, input logic t, input logic [4:0] b, input logic l);
      int n;
      n = 0;
      while (!rdy8 && n < 400) begin tick(); n++; end
      if (!rdy8) timeout("ready_wait");
      data = d; typ = t; bytes = b; last = l; valid = 1'b1;
      tick();
      valid = 1'b0; last = 1'b0;
   endtask

   task automatic send_final();
      fin = 1'b1;
      tick();
      fin = 1'b0;
   endtask

   // cyc counts clocks from the accepting edge to the first cycle with o_tag_valid.
   task automatic wait_tag(output int cyc);
      cyc = 1;
      while (!tv8 && cyc < 1000) begin tick(); cyc++; end
      if (!tv8) timeout("tag_wait");
   endtask

   typedef struct {
      logic [127:0] h;
      logic [127:0] ek0;
      logic [127:0] data;
      int           nblk;
      logic         typ;
      logic [4:0]   bytes;
      logic [127:0] exp_tag;
      int           exp_cyc;
   } vec_t;

   vec_t         vt [4];
   int           cyc, c1, c8, c128, na, nc, total;
   logic [127:0] y, hh, ee, d, t1, t8, t128;
   logic [63:0]  abits, cbits;
   logic [4:0]   b;
   logic         t;

   initial begin
      rst_n = 1'b0; start = 1'b0; valid = 1'b0; typ = 1'b0; last = 1'b0; fin = 1'b0;
      h_in = 128'd0; ek0_in = 128'd0; data = 128'd0; bytes = 5'd0;
      repeat (3) tick();
      check("reset_ready", 128'(rdy8), 128'd0);
      check("reset_tag_valid", 128'(tv8), 128'd0);
      check("reset_tag", tag8, 128'd0);
      check("reset_error", 128'(err8), 128'd0);
      rst_n = 1'b1;
      tick();
      check("idle_ready", 128'(rdy8), 128'd0);

      vt[0] = '{128'd0, TC_EK0, 128'd0, 0, 1'b0, 5'd16, TC_EK0, M8 + 2};
      vt[1] = '{TC_H, TC_EK0, TC_C, 1, 1'b1, 5'd16, TC_TAG, 2*M8 + 2};
      vt[2] = '{ID_H, 128'd0, 128'h0123456789abcdef0123456789abcdef, 1, 1'b0, 5'd5,
                128'h0123456789000028_0000000000000000, 2*M8 + 2};
      vt[3] = '{ID_H, 128'd0, {128{1'b1}}, 1, 1'b1, 5'd16,
                128'hffffffffffffffff_ffffffffffffff7f, 2*M8 + 2};
      for (int i = 0; i < 4; i++) begin
         begin_msg(vt[i].h, vt[i].ek0);
         if (vt[i].nblk == 0) send_final();
         else send(vt[i].data, vt[i].typ, vt[i].bytes, 1'b1);
         wait_tag(cyc);
         check($sformatf("vec%0d_tag", i), tag8, vt[i].exp_tag);
         check($sformatf("vec%0d_latency", i), 128'(cyc), 128'(vt[i].exp_cyc));
         repeat (3) tick();
         check($sformatf("vec%0d_tag_held", i), 128'(tv8), 128'd1);
      end

      // Test case 2 on all three digit widths at once.
      begin_msg(TC_H, TC_EK0);
      send(TC_C, 1'b1, 5'd16, 1'b1);
      c1 = 0; c8 = 0; c128 = 0; cyc = 1;
      t1 = 128'd0; t8 = 128'd0; t128 = 128'd0;
      while ((c1 == 0 || c8 == 0 || c128 == 0) && cyc < 400) begin
         if (tv1 && c1 == 0) begin c1 = cyc; t1 = tag1; end
         if (tv8 && c8 == 0) begin c8 = cyc; t8 = tag8; end
         if (tv128 && c128 == 0) begin c128 = cyc; t128 = tag128; end
         tick();
         cyc++;
      end
      check("w1_tag", t1, TC_TAG);
      check("w1_latency", 128'(c1), 128'(2*128 + 2));
      check("w8_tag", t8, TC_TAG);
      check("w8_latency", 128'(c8), 128'(2*M8 + 2));
      check("w128_tag", t128, TC_TAG);
      check("w128_latency", 128'(c128), 128'(2*1 + 2));

      // AAD after CT is dropped and flagged; the rest of the message still hashes.
      begin_msg(ID_H, 128'd0);
      send(128'h11112222333344445555666677778888, 1'b1, 5'd16, 1'b0);
      send(128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b0, 5'd16, 1'b0);
      check("err_aad_after_ct", 128'(err8), 128'd1);
      check("err_ready_kept", 128'(rdy8), 128'd1);
      send(128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 5'd16, 1'b1);
      wait_tag(cyc);
      y = gf_mul(128'h11112222333344445555666677778888, ID_H);
      y = gf_mul(y ^ 128'h0f0e0d0c0b0a09080706050403020100, ID_H);
      y = gf_mul(y ^ {64'd0, 64'd256}, ID_H);
      check("err_block_dropped_tag", tag8, y);
      check("err_sticky", 128'(err8), 128'd1);
      begin_msg(ID_H, 128'd0);
      check("err_cleared_by_start", 128'(err8), 128'd0);
      check("tag_valid_cleared_by_start", 128'(tv8), 128'd0);
      send(128'h1, 1'b1, 5'd4, 1'b0);
      send(128'h2, 1'b1, 5'd16, 1'b1);
      check("err_partial_then_more", 128'(err8), 128'd1);
      begin_msg(ID_H, 128'd0);
      send(128'h3, 1'b0, 5'd0, 1'b1);
      check("err_bytes_zero", 128'(err8), 128'd1);
      begin_msg(ID_H, 128'd0);
      send(128'h4, 1'b0, 5'd17, 1'b1);
      check("err_bytes_17", 128'(err8), 128'd1);

      // Abort mid-multiply, then run test case 2.
      begin_msg(TC_EK0, TC_H);
      send(128'haaaa, 1'b0, 5'd16, 1'b0);
      send(128'hbbbb, 1'b1, 5'd16, 1'b0);
      tick(); tick();
      check("abort_in_mult_busy", 128'(rdy8), 128'd0);
      begin_msg(TC_H, TC_EK0);
      check("abort_no_stale_tag", 128'(tv8), 128'd0);
      send(TC_C, 1'b1, 5'd16, 1'b1);
      wait_tag(cyc);
      check("abort_tc2_tag", tag8, TC_TAG);

      // Start together with valid in ACCEPT: the block is ignored.
      begin_msg(ID_H, 128'd0);
      h_in = TC_H; ek0_in = TC_EK0; data = 128'hcafe; typ = 1'b1; bytes = 5'd16;
      last = 1'b1; valid = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; valid = 1'b0; last = 1'b0;
      send(TC_C, 1'b1, 5'd16, 1'b1);
      wait_tag(cyc);
      check("start_with_valid_tag", tag8, TC_TAG);
      check("start_with_valid_latency", 128'(cyc), 128'(2*M8 + 2));

      // Random messages against the model.
      for (int m = 0; m < 25; m++) begin
         hh = {$urandom, $urandom, $urandom, $urandom};
         ee = {$urandom, $urandom, $urandom, $urandom};
         na = $urandom_range(0, 3);
         nc = $urandom_range(0, 3);
         total = na + nc;
         begin_msg(hh, ee);
         y = 128'd0; abits = 64'd0; cbits = 64'd0;
         for (int k = 0; k < total; k++) begin
            t = (k >= na);
            b = ((t && k == total - 1) || (!t && k == na - 1)) ? 5'($urandom_range(1, 16)) : 5'd16;
            d = {$urandom, $urandom, $urandom, $urandom};
            y = gf_mul(y ^ pad_ref(d, b), hh);
            if (t) cbits = cbits + 64'(8 * int'(b));
            else abits = abits + 64'(8 * int'(b));
            send(d, t, b, k == total - 1);
         end
         if (total == 0) send_final();
         wait_tag(cyc);
         y = gf_mul(y ^ {abits, cbits}, hh) ^ ee;
         check($sformatf("rand%0d_tag", m), tag8, y);
         check($sformatf("rand%0d_latency", m), 128'(cyc), 128'((total == 0) ? (M8 + 2) : (2*M8 + 2)));
         check($sformatf("rand%0d_error", m), 128'(err8), 128'd0);
      end

      // Reset pulse during LEN_MULT.
      begin_msg(TC_H, TC_EK0);
      send(TC_C, 1'b1, 5'd16, 1'b1);
      repeat (M8 + 3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_tag", tag8, 128'd0);
      check("rst_async_tag_valid", 128'(tv8), 128'd0);
      check("rst_async_ready", 128'(rdy8), 128'd0);
      check("rst_async_error", 128'(err8), 128'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check("rst_release_ready", 128'(rdy8), 128'd0);
      repeat (40) tick();
      check("rst_no_tag", 128'(tv8), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
